// File: rtl/psum_buf_arbiter.sv
// ============================================================================
// Module   : psum_buf_arbiter
// Brief    : Single-port psum SRAM arbiter for the accumulator and drain paths,
//            with accumulator lock sequences, lock watchdog and read routing.
//            Define PSUM_ARB_FIXED_PRIO_EN for fixed acc-over-drn arbitration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_buf_arbiter #(
    parameter int DATA_W   = 256,
    parameter int ADDR_W   = 10,
    parameter int LOCK_MAX = 15
) (
    input  logic              core_clk,
    input  logic              rst_n,
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    input  logic              acc_lock,
    input  logic              drn_req,
    input  logic              drn_we,
    input  logic [ADDR_W-1:0] drn_addr,
    input  logic [DATA_W-1:0] drn_wdata,
    output logic              acc_gnt,
    output logic              drn_gnt,
    output logic              acc_rvalid,
    output logic              drn_rvalid,
    output logic [DATA_W-1:0] acc_rdata,
    output logic [DATA_W-1:0] drn_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lock_timeout
);

    localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    localparam logic [0:0] S_IDLE       = 1'b0;
    localparam logic [0:0] S_ACC_LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] lock_cnt_inc;
    logic             relock_blk_q, relock_blk_d;
    logic             timeout_q, timeout_d;
    logic             rd_acc_q, rd_drn_q;
    logic             acc_win, drn_win;

`ifndef PSUM_ARB_FIXED_PRIO_EN
    // 1 = drain won last, so the accumulator wins the first contention
    logic             rr_last_q, rr_last_d;
`endif

    always_comb begin
        acc_win = 1'b0;
        drn_win = 1'b0;
        if (state_q == S_ACC_LOCKED) begin
            acc_win = acc_req;
        end else if (acc_req && drn_req) begin
`ifdef PSUM_ARB_FIXED_PRIO_EN
            acc_win = 1'b1;
`else
            acc_win = rr_last_q;
            drn_win = ~rr_last_q;
`endif
        end else begin
            acc_win = acc_req;
            drn_win = drn_req;
        end
    end

    assign acc_gnt = acc_win;
    assign drn_gnt = drn_win;

    // Idle bus is forced to zero so requester-side X never reaches the SRAM
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (acc_win) begin
            mem_en    = 1'b1;
            mem_we    = acc_we;
            mem_addr  = acc_addr;
            mem_wdata = acc_wdata;
        end else if (drn_win) begin
            mem_en    = 1'b1;
            mem_we    = drn_we;
            mem_addr  = drn_addr;
            mem_wdata = drn_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        relock_blk_d = relock_blk_q & acc_lock;
        timeout_d    = timeout_q;
        lock_cnt_inc = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
        if (state_q == S_ACC_LOCKED) begin
            lock_cnt_d = lock_cnt_inc;
            if (!acc_lock) begin
                state_d = S_IDLE;
            end else if (lock_cnt_inc == CNT_MAX) begin
                state_d      = S_IDLE;
                timeout_d    = 1'b1;
                relock_blk_d = 1'b1;
            end
        end else if (acc_win && acc_lock && !relock_blk_q) begin
            state_d    = S_ACC_LOCKED;
            lock_cnt_d = '0;
        end
    end

`ifndef PSUM_ARB_FIXED_PRIO_EN
    always_comb begin
        rr_last_d = rr_last_q;
        if (acc_win) begin
            rr_last_d = 1'b0;
        end else if (drn_win) begin
            rr_last_d = 1'b1;
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lock_cnt_q   <= '0;
            relock_blk_q <= 1'b0;
            timeout_q    <= 1'b0;
            rd_acc_q     <= 1'b0;
            rd_drn_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            relock_blk_q <= relock_blk_d;
            timeout_q    <= timeout_d;
            rd_acc_q     <= acc_win & ~acc_we;
            rd_drn_q     <= drn_win & ~drn_we;
        end
    end

    assign acc_rvalid   = rd_acc_q;
    assign drn_rvalid   = rd_drn_q;
    assign acc_rdata    = mem_rdata;
    assign drn_rdata    = mem_rdata;
    assign lock_timeout = timeout_q;

endmodule

`default_nettype wire
